// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: signed WIDTH x WIDTH -> 2*WIDTH product,
// one iteration per clock, result registered and held until the next start.
module booth_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic [2*WIDTH-1:0]   salida,
    output logic                 done
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 q1_q, q1_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0]   salida_q, salida_d;
    logic                 done_q, done_d;

    logic [WIDTH:0]       m_ext;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       a_shift;
    logic [WIDTH-1:0]     q_shift;
    logic                 q1_shift;

    // One Booth step: add/subtract M into the extra-wide accumulator, then
    // arithmetic right shift of {A,Q,Q_1}. The guard bit keeps -2^(WIDTH-1) exact.
    always_comb begin
        m_ext = {m_q[WIDTH-1], m_q};
        unique case ({q_q[0], q1_q})
            2'b01:   sum = a_q + m_ext;
            2'b10:   sum = a_q - m_ext;
            default: sum = a_q;
        endcase
        a_shift  = {sum[WIDTH], sum[WIDTH:1]};
        q_shift  = {sum[0], q_q[WIDTH-1:1]};
        q1_shift = q_q[0];
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        q_d      = q_q;
        q1_d     = q1_q;
        m_d      = m_q;
        count_d  = count_q;
        salida_d = salida_q;
        done_d   = done_q;

        if (start) begin
            // Load restarts from any state; salida keeps the previous result.
            m_d     = x;
            q_d     = y;
            a_d     = '0;
            q1_d    = 1'b0;
            count_d = CntW'(WIDTH);
            done_d  = 1'b0;
            state_d = StBusy;
        end else begin
            unique case (state_q)
                StBusy: begin
                    a_d     = a_shift;
                    q_d     = q_shift;
                    q1_d    = q1_shift;
                    count_d = count_q - CntW'(1);
                    if (count_q == CntW'(1)) begin
                        salida_d = {a_shift[WIDTH-1:0], q_shift};
                        done_d   = 1'b1;
                        state_d  = StDone;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            q_q      <= '0;
            q1_q     <= 1'b0;
            m_q      <= '0;
            count_q  <= '0;
            salida_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            q_q      <= q_d;
            q1_q     <= q1_d;
            m_q      <= m_d;
            count_q  <= count_d;
            salida_q <= salida_d;
            done_q   <= done_d;
        end
    end

    assign salida = salida_q;
    assign done   = done_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed cases plus random operand
// pairs compared against a plain signed-multiply reference.
module tb_booth_multiplier;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned PW    = 2 * WIDTH;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [WIDTH-1:0]  x;
    logic [WIDTH-1:0]  y;
    logic [PW-1:0]     salida;
    logic              done;

    int n_tests;
    int n_fail;

    booth_multiplier #(
        .WIDTH(WIDTH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .x      (x),
        .y      (y),
        .salida (salida),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_product(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        int sa;
        int sb;
        int p;
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
        return p[PW-1:0];
    endfunction

    // Pulse start for one edge; returns after the load edge (+1).
    task automatic pulse_start(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv);
        @(negedge clk);
        x     = xv;
        y     = yv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Full operation with latency checks; operands are scrambled while busy.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] xv,
                          input logic [WIDTH-1:0] yv);
        logic [PW-1:0] exp;
        exp = ref_product(xv, yv);
        pulse_start(xv, yv);
        check_eq({tag, "_done_after_load"}, 32'(done), 32'd0);
        for (int i = 1; i <= int'(WIDTH); i++) begin
            x = WIDTH'($urandom);
            y = WIDTH'($urandom);
            @(posedge clk);
            #1;
            if (i < int'(WIDTH)) begin
                check_eq({tag, "_done_early"}, 32'(done), 32'd0);
            end else begin
                check_eq({tag, "_done"}, 32'(done), 32'd1);
                check_eq({tag, "_salida"}, 32'(salida), 32'(exp));
            end
        end
    endtask

    initial begin
        logic [WIDTH-1:0] rx;
        logic [WIDTH-1:0] ry;
        logic [PW-1:0]    held;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        x       = '0;
        y       = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_salida", 32'(salida), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("two_by_two", 4'b0010, 4'b0010);
        held = ref_product(4'b0010, 4'b0010);
        repeat (20) @(posedge clk);
        #1;
        check_eq("hold_done", 32'(done), 32'd1);
        check_eq("hold_salida", 32'(salida), 32'(held));

        run_op("neg3_by_5", 4'b1101, 4'b0101);
        check_eq("neg3_by_5_const", 32'(salida), 32'h0000_00f1);
        run_op("min_by_min", 4'b1000, 4'b1000);
        check_eq("min_by_min_const", 32'(salida), 32'h0000_0040);
        run_op("7_by_min", 4'b0111, 4'b1000);
        check_eq("7_by_min_const", 32'(salida), 32'h0000_00c8);
        run_op("zero_x", 4'b0000, 4'b1011);
        run_op("neg1_by_neg1", 4'b1111, 4'b1111);
        check_eq("neg1_by_neg1_const", 32'(salida), 32'h0000_0001);

        // Restart mid-operation: first result must never appear.
        pulse_start(4'b0011, 4'b0011);
        repeat (2) @(posedge clk);
        #1;
        check_eq("restart_pre_done", 32'(done), 32'd0);
        run_op("restart", 4'b0010, 4'b0110);
        check_eq("restart_const", 32'(salida), 32'h0000_000c);

        // Asynchronous reset mid-operation.
        pulse_start(4'b0101, 4'b0011);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_salida", 32'(salida), 32'd0);
        check_eq("rst_mid_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (WIDTH + 2) @(posedge clk);
        #1;
        check_eq("rst_mid_no_done", 32'(done), 32'd0);
        check_eq("rst_mid_no_salida", 32'(salida), 32'd0);

        // start held high reloads every edge and never completes.
        @(negedge clk);
        x     = 4'b0011;
        y     = 4'b0010;
        start = 1'b1;
        repeat (WIDTH + 3) @(posedge clk);
        #1;
        check_eq("start_held_done", 32'(done), 32'd0);
        start = 1'b0;
        repeat (WIDTH) @(posedge clk);
        #1;
        check_eq("start_release_done", 32'(done), 32'd1);
        check_eq("start_release_salida", 32'(salida), 32'(ref_product(4'b0011, 4'b0010)));

        for (int n = 0; n < 60; n++) begin
            rx = WIDTH'($urandom);
            ry = WIDTH'($urandom);
            run_op("random", rx, ry);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
